fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction fetch controller sitting between the PC logic and the 64-word instruction ROM (6-bit word address, 32-bit combinational read).
- Owns the program counter and drives the ROM address. Buffers fetched words in a small in-order queue and hands them to decode over a valid/ready handshake.
- Supports branch redirect with queue flush. Halts on the all-zero end-of-program word or on an out-of-range PC.

Parameters:
- N, 64, PC / redirect address width in bits (N >= 8).
- DEPTH, 4, instruction queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  load redirect_pc this cycle.
- redirect_pc  in  N  new fetch address (byte address).
- imem_addr  out  6  ROM word address = fetch_pc[7:2], combinational.
- imem_q  in  32  ROM read data for imem_addr, same cycle.
- inst_valid  out  1  queue head holds an instruction.
- inst_ready  in  1  decode accepts head this cycle.
- inst  out  32  queue head instruction word.
- inst_pc  out  N  byte address of inst.
- fetch_pc  out  N  current fetch PC.
- halted  out  1  state == HALTED.
- count  out  clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (reset==0, asynchronous): fetch_pc=0, queue empty, count=0, state=FETCH. Outputs inst_valid=0, halted=0, inst=0, inst_pc=0.
- States: FETCH, HALTED.
- Fetch condition, evaluated in FETCH: count < DEPTH (start-of-cycle value), fetch_pc[N-1:8]==0, imem_q != 0.
  - If all three hold: enqueue {imem_q, fetch_pc} at the tail on the clock edge and set fetch_pc += 4.
  - Latency: ROM word at PC p is visible on inst at the earliest 1 cycle after fetch_pc==p.
- Full queue (count==DEPTH at start of cycle): no enqueue, fetch_pc holds, even if a dequeue happens in the same cycle.
- End marker: in FETCH with count<DEPTH and imem_q==32'h0:
  - no enqueue; fetch_pc holds at the zero word's address; next state HALTED.
  - Already-queued instructions still drain normally.
- Out of range: in FETCH with fetch_pc[N-1:8]!=0: no enqueue; next state HALTED. imem_addr still shows fetch_pc[7:2]; its value is don't-care.
- Misaligned PC (fetch_pc[1:0]!=0): bits ignored for addressing and kept in inst_pc unchanged.
- HALTED: no fetch, fetch_pc holds. Only redirect_valid leaves HALTED.
- Dequeue: when inst_valid && inst_ready, head pops on the edge.
  - inst_valid = (count != 0).
  - inst and inst_pc are the head entry, registered outputs with no combinational path from inst_ready.
  - When empty, inst and inst_pc hold their last value.
- Simultaneous enqueue and dequeue with count<DEPTH: count unchanged, order preserved.
- Redirect (highest priority, any state): on the edge:
  - queue flushed (count=0), fetch_pc=redirect_pc, state=FETCH; no enqueue that cycle.
  - A handshake in the same cycle counts as a completed transfer; its entry is discarded with the rest.
  - First fetch from redirect_pc occurs the following cycle.
- Queue pointers are modulo DEPTH. count saturates by construction; it never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk. Release is synchronous to the next rising edge as usual.

Test Plan:
- Straight line:
  - Stimulus: test ROM words 0..7 = 8b1f03e2, cb1e0003, b40000a3, f8000040, 8b000020, 8b080042, b4ffff7f, b400001f, words 8..63 = 0. Release reset, inst_ready=1.
  - Response: eight transfers in order with inst_pc 0x0,0x4,...,0x1C. halted=1 after fetch_pc reaches 0x20. fetch_pc stays 0x20, inst_valid=0 after drain.
- Backpressure:
  - Stimulus: same ROM, inst_ready=0.
  - Response: count reaches 4 after 4 cycles, fetch_pc=0x10 and holds. inst=8b1f03e2 held stable. Raising inst_ready drains the words in order, then fetch resumes to word 7.
- Redirect flush:
  - Stimulus: inst_ready=0 with count=3, pulse redirect_valid, redirect_pc=0x8.
  - Response: next cycle count=0, fetch_pc=0x8, inst_valid=0. One cycle later inst=b40000a3, inst_pc=0x8.
- Resume from halt:
  - Stimulus: in HALTED at 0x20, redirect to 0x18.
  - Response: halted=0 next cycle. Transfers b4ffff7f (pc 0x18) and b400001f (pc 0x1C), then halted=1 again.
- Out of range:
  - Stimulus: redirect to 0x100.
  - Response: next cycle FETCH, then HALTED with no enqueue. count=0, fetch_pc=0x100.
- Async reset:
  - Stimulus: drop reset between clock edges while count=2.
  - Response: inst_valid=0, count=0, fetch_pc=0, halted=0 immediately, before the next edge. The normal sequence restarts after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads the 64-word ROM and buffers
// fetched words in an in-order queue that decode drains over valid/ready.
module fetch_sequencer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [N-1:0]             redirect_pc,
  output logic [5:0]               imem_addr,
  input  logic [31:0]              imem_q,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [N-1:0]             inst_pc,
  output logic [N-1:0]             fetch_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   mem_inst [DEPTH];
  logic [N-1:0]  mem_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_adv;

  logic          pc_in_range;
  logic          full;
  logic          enq;
  logic          deq;
  logic [N-1:0]  pc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] remain;
  logic [31:0]   head_inst;
  logic [N-1:0]  head_pc;

  // Misaligned low bits are simply dropped from the ROM word address.
  assign imem_addr   = fetch_pc[7:2];
  assign pc_in_range = ((fetch_pc >> 8) == '0);
  assign full        = (count == CW'(DEPTH));
  assign inst_valid  = (count != '0);
  assign deq         = inst_valid && inst_ready;
  assign halted      = (state == HALTED);
  assign rd_ptr_adv  = deq ? (rd_ptr + AW'(1)) : rd_ptr;

  // Next state, enqueue decision and next PC; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    enq       = 1'b0;
    pc_nxt    = fetch_pc;
    if (redirect_valid) begin
      state_nxt = FETCH;
      pc_nxt    = redirect_pc;
    end else if (state == FETCH) begin
      if (!pc_in_range) begin
        state_nxt = HALTED;
      end else if (!full) begin
        if (imem_q == 32'h0) begin
          state_nxt = HALTED;
        end else begin
          enq    = 1'b1;
          pc_nxt = fetch_pc + N'(4);
        end
      end
    end
  end

  // Occupancy update and selection of the head entry that will be visible
  // after the edge, so inst/inst_pc can be registered without a path from
  // inst_ready.
  always_comb begin
    cnt_nxt   = count;
    remain    = count - CW'(deq);
    head_inst = inst;
    head_pc   = inst_pc;
    if (redirect_valid) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = count + CW'(enq) - CW'(deq);
      if (remain != '0) begin
        head_inst = mem_inst[rd_ptr_adv];
        head_pc   = mem_pc[rd_ptr_adv];
      end else if (enq) begin
        head_inst = imem_q;
        head_pc   = fetch_pc;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, queue pointers, occupancy and registered head outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inst     <= '0;
      inst_pc  <= '0;
    end else begin
      fetch_pc <= pc_nxt;
      count    <= cnt_nxt;
      inst     <= head_inst;
      inst_pc  <= head_pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_inst[wr_ptr] <= imem_q;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
